// File: rtl/display_one_digit.sv
// Registered single-digit 7-segment driver.
// Decodes a 4-bit value into an abcdefg pattern with blanking, lamp test,
// optional hex glyphs and selectable output polarity; one cycle of latency.
module display_one_digit #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] x,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] z
);

  // Fully lit and fully dark patterns at the output polarity.
  localparam logic [6:0] ALL_OFF = ACTIVE_LOW ? 7'b111_1111 : 7'b000_0000;

  logic [6:0] seg_hi;   // active-high glyph for x
  logic [6:0] pattern;  // active-high pattern after lamp test / blanking
  logic [6:0] z_next;   // pattern at output polarity

  // Active-high glyph lookup; hex codes collapse to dark when disabled.
  always_comb begin
    seg_hi = '0;
    unique case (x)
      4'h0: seg_hi = 7'b111_1110;
      4'h1: seg_hi = 7'b011_0000;
      4'h2: seg_hi = 7'b110_1101;
      4'h3: seg_hi = 7'b111_1001;
      4'h4: seg_hi = 7'b011_0011;
      4'h5: seg_hi = 7'b101_1011;
      4'h6: seg_hi = 7'b101_1111;
      4'h7: seg_hi = 7'b111_0000;
      4'h8: seg_hi = 7'b111_1111;
      4'h9: seg_hi = 7'b111_1011;
      4'hA: seg_hi = HEX_EN ? 7'b111_0111 : 7'b000_0000;
      4'hB: seg_hi = HEX_EN ? 7'b001_1111 : 7'b000_0000;
      4'hC: seg_hi = HEX_EN ? 7'b100_1110 : 7'b000_0000;
      4'hD: seg_hi = HEX_EN ? 7'b011_1101 : 7'b000_0000;
      4'hE: seg_hi = HEX_EN ? 7'b100_1111 : 7'b000_0000;
      4'hF: seg_hi = HEX_EN ? 7'b100_0111 : 7'b000_0000;
      default: seg_hi = '0;
    endcase
  end

  // Lamp test beats blanking, blanking beats decode; then apply polarity.
  always_comb begin
    pattern = seg_hi;
    if (lamp_test) begin
      pattern = '1;
    end else if (blank) begin
      pattern = '0;
    end
    z_next = ACTIVE_LOW ? ~pattern : pattern;
  end

  // Output register; synchronous reset forces all segments dark.
  always_ff @(posedge clock) begin
    if (reset) begin
      z <= ALL_OFF;
    end else begin
      z <= z_next;
    end
  end

endmodule

// File: tb/tb_display_one_digit.sv
// Self-checking bench for display_one_digit: directed vector table,
// a parameter-variant sequence, and randomized inputs against a model.
module tb_display_one_digit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] x = 4'd8;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] z_def;   // ACTIVE_LOW=1, HEX_EN=1
  logic [6:0] z_alt;   // ACTIVE_LOW=0, HEX_EN=0

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  display_one_digit #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_def (
    .clock(clock), .reset(reset), .x(x), .blank(blank),
    .lamp_test(lamp_test), .z(z_def)
  );

  display_one_digit #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_alt (
    .clock(clock), .reset(reset), .x(x), .blank(blank),
    .lamp_test(lamp_test), .z(z_alt)
  );

  // Glyphs as written in the segment chart, abcdefg, lit = 1.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference: what the digit should show for one sampled set of inputs.
  function automatic logic [6:0] model(input bit al, input bit hex,
                                       input bit rst, input bit lt,
                                       input bit bl, input logic [3:0] v);
    logic [6:0] lit;
    if (rst || (bl && !lt))   lit = 7'b0000000;
    else if (lt)              lit = 7'b1111111;
    else if (v >= 10 && !hex) lit = 7'b0000000;
    else                      lit = glyph[v];
    return al ? ~lit : lit;
  endfunction

  task automatic check(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         lt;
    bit         bl;
    logic [3:0] v;
    logic [6:0] exp;   // expected z of the default instance after the edge
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [6:0] prev;
    bit r, l, b;
    logic [3:0] v;

    // reset with x=8, then release
    vecs.push_back('{1, 0, 0, 4'd8, 7'b1111111});
    vecs.push_back('{1, 0, 0, 4'd8, 7'b1111111});
    vecs.push_back('{0, 0, 0, 4'd8, 7'b0000000});
    // sweep samples
    vecs.push_back('{0, 0, 0, 4'd0, 7'b0000001});
    vecs.push_back('{0, 0, 0, 4'd1, 7'b1001111});
    vecs.push_back('{0, 0, 0, 4'hA, 7'b0001000});
    vecs.push_back('{0, 0, 0, 4'hF, 7'b0111000});
    // priority with x=3
    vecs.push_back('{0, 0, 1, 4'd3, 7'b1111111});
    vecs.push_back('{0, 1, 1, 4'd3, 7'b0000000});
    vecs.push_back('{1, 1, 0, 4'd3, 7'b1111111});
    vecs.push_back('{0, 0, 0, 4'd3, 7'b0000110});
    // back-to-back values
    vecs.push_back('{0, 0, 0, 4'd7, 7'b0001111});
    vecs.push_back('{0, 0, 0, 4'd2, 7'b0010010});
    vecs.push_back('{0, 0, 0, 4'd9, 7'b0000100});
    // one-cycle reset pulse mid-stream
    vecs.push_back('{0, 0, 0, 4'd4, 7'b1001100});
    vecs.push_back('{1, 0, 0, 4'd5, 7'b1111111});
    vecs.push_back('{0, 0, 0, 4'd5, 7'b0100100});

    prev = 7'b1111111;
    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst; lamp_test = vecs[i].lt;
      blank = vecs[i].bl;  x = vecs[i].v;
      #4;
      if (i > 0) check($sformatf("hold[%0d]", i), z_def, prev);
      @(posedge clock); #1;
      check($sformatf("vec[%0d]", i), z_def, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // full sweep of the default instance
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      reset = 0; lamp_test = 0; blank = 0; x = 4'(k);
      @(posedge clock); #1;
      check($sformatf("sweep[%0d]", k), z_def, ~glyph[k]);
    end

    // active-high, hex disabled
    @(negedge clock); x = 4'd5;
    @(posedge clock); #1; check("alt x=5", z_alt, 7'b1011011);
    @(negedge clock); x = 4'd12;
    @(posedge clock); #1; check("alt x=12", z_alt, 7'b0000000);
    @(negedge clock); x = 4'd9;
    @(posedge clock); #1; check("alt x=9", z_alt, 7'b1111011);

    // randomized stimulus on both instances
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      r = ($urandom_range(15) == 0);
      l = ($urandom_range(7) == 0);
      b = ($urandom_range(7) == 0);
      v = 4'($urandom_range(15));
      reset = r; lamp_test = l; blank = b; x = v;
      @(posedge clock); #1;
      check("rand def", z_def, model(1'b1, 1'b1, r, l, b, v));
      check("rand alt", z_alt, model(1'b0, 1'b0, r, l, b, v));
      // inputs scrambled mid-cycle must not disturb the register
      #2;
      x = 4'($urandom_range(15)); lamp_test = ~l; blank = ~b; reset = ~r;
      #1;
      check("rand hold", z_def, model(1'b1, 1'b1, r, l, b, v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
